// File: rtl/dual_write_dual_read_ram_if.sv
// ---------------------------------------------------------------------------
// dual_write_dual_read_ram_if
//   Bus bundle for the two-write / two-read register RAM.
//   master : agent side. It drives the write and read requests and receives
//            the read data and collision flags.
//   slave  : RAM side.
//   Signals per port pair N (1 or 2):
//     wrenN/wraddrN/wrdataN     write request
//     rdenN/rdaddrN             read request
//     rddataN/rdcollisionN      registered read response, 1-cycle latency
// ---------------------------------------------------------------------------
interface dual_write_dual_read_ram_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
);
  logic                  wren1;
  logic [ADDR_WIDTH-1:0] wraddr1;
  logic [DATA_WIDTH-1:0] wrdata1;
  logic                  wren2;
  logic [ADDR_WIDTH-1:0] wraddr2;
  logic [DATA_WIDTH-1:0] wrdata2;
  logic                  rden1;
  logic [ADDR_WIDTH-1:0] rdaddr1;
  logic [DATA_WIDTH-1:0] rddata1;
  logic [1:0]            rdcollision1;
  logic                  rden2;
  logic [ADDR_WIDTH-1:0] rdaddr2;
  logic [DATA_WIDTH-1:0] rddata2;
  logic [1:0]            rdcollision2;

  modport master (
    output wren1, wraddr1, wrdata1, wren2, wraddr2, wrdata2,
    output rden1, rdaddr1, rden2, rdaddr2,
    input  rddata1, rdcollision1, rddata2, rdcollision2
  );

  modport slave (
    input  wren1, wraddr1, wrdata1, wren2, wraddr2, wrdata2,
    input  rden1, rdaddr1, rden2, rdaddr2,
    output rddata1, rdcollision1, rddata2, rdcollision2
  );
endinterface

// File: rtl/dual_write_dual_read_ram.sv
// ---------------------------------------------------------------------------
// dual_write_dual_read_ram
//   Register-based RAM with two write ports and two read ports on one clock.
//   Ports:
//     aclk     clock. All state changes on the rising edge.
//     aresetn  asynchronous active-low reset. It clears every word, the read
//              data and the collision flags.
//     bus      dual_write_dual_read_ram_if.slave. It carries the write and
//              read requests and the read responses of both port pairs.
//   Parameters:
//     WRITE_COLLISION=1 : on a same-address dual write, write port 1 wins.
//     READ_COLLISION=1  : a read that hits a word being written in the same
//                         cycle returns the new data and flags which write
//                         port(s) it hit.
//   Addresses at or above RAM_DEPTH are dropped on writes and read as 0.
// ---------------------------------------------------------------------------

// One read port. It holds the registered output and the bypass/collision
// logic. The design instantiates one copy per read port.
module dwdr_rd_port #(
  parameter int ADDR_WIDTH      = 3,
  parameter int RAM_DEPTH       = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_WR          = 2,
  parameter int WRITE_COLLISION = 1,
  parameter int READ_COLLISION  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rden,
  input  logic [ADDR_WIDTH-1:0]                rdaddr,
  input  logic [RAM_DEPTH-1:0][DATA_WIDTH-1:0] mem,
  input  logic [NUM_WR-1:0]                    wren,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wraddr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wrdata,
  output logic [DATA_WIDTH-1:0]                rddata,
  output logic [NUM_WR-1:0]                    rdcollision
);
  logic [DATA_WIDTH-1:0] old_data;
  logic [DATA_WIDTH-1:0] nxt_data;
  logic [NUM_WR-1:0]     hit;
  logic                  in_range;

  // Word select is a compare loop rather than a direct index. This keeps
  // out-of-range addresses reading 0 when RAM_DEPTH < 2**ADDR_WIDTH.
  always_comb begin
    old_data = '0;
    in_range = 1'b0;
    for (int w = 0; w < RAM_DEPTH; w++) begin
      if (rdaddr == ADDR_WIDTH'(w)) begin
        old_data = mem[w];
        in_range = 1'b1;
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_WR; p++)
      hit[p] = wren[p] && (wraddr[p] == rdaddr);
  end

  // The bypass priority must match the write arbitration in the array, so a
  // bypassed read equals what the word holds after the edge.
  always_comb begin
    nxt_data = old_data;
    if (READ_COLLISION != 0 && in_range) begin
      if (hit[0] && (WRITE_COLLISION != 0 || !hit[1])) nxt_data = wrdata[0];
      else if (hit[1])                                 nxt_data = wrdata[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rddata      <= '0;
      rdcollision <= '0;
    end else if (rden) begin
      rddata      <= nxt_data;
      rdcollision <= (READ_COLLISION != 0) ? hit : '0;
    end else begin
      // Idle port: the data holds and the flags drop.
      rdcollision <= '0;
    end
  end
endmodule

module dual_write_dual_read_ram #(
  parameter int ADDR_WIDTH      = 3,
  parameter int RAM_DEPTH       = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH      = 8,
  parameter int WRITE_COLLISION = 1,
  parameter int READ_COLLISION  = 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  dual_write_dual_read_ram_if.slave    bus
);
  localparam int NUM_WR = 2;
  localparam int NUM_RD = 2;

  logic [NUM_WR-1:0]                    wren;
  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]    wraddr;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0]    wrdata;
  logic [NUM_RD-1:0]                    rden;
  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rdaddr;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rddata;
  logic [NUM_RD-1:0][NUM_WR-1:0]        rdcollision;
  logic [RAM_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [RAM_DEPTH-1:0][NUM_WR-1:0]     wsel;

  // Pack the named interface signals into per-port arrays. All logic below
  // is then written once and indexed by port.
  assign wren   = {bus.wren2,   bus.wren1};
  assign wraddr = {bus.wraddr2, bus.wraddr1};
  assign wrdata = {bus.wrdata2, bus.wrdata1};
  assign rden   = {bus.rden2,   bus.rden1};
  assign rdaddr = {bus.rdaddr2, bus.rdaddr1};

  assign bus.rddata1      = rddata[0];
  assign bus.rddata2      = rddata[1];
  assign bus.rdcollision1 = rdcollision[0];
  assign bus.rdcollision2 = rdcollision[1];

  // Per-word write decode. An out-of-range address matches no word, so that
  // write is dropped.
  always_comb begin
    for (int w = 0; w < RAM_DEPTH; w++)
      for (int p = 0; p < NUM_WR; p++)
        wsel[w][p] = wren[p] && (wraddr[p] == ADDR_WIDTH'(w));
  end

  // With arbitration on, port 1 takes a contested word. With arbitration
  // off, port 2 happens to land last; that result is not guaranteed.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem <= '0;
    end else begin
      for (int w = 0; w < RAM_DEPTH; w++) begin
        if (wsel[w][0] && (WRITE_COLLISION != 0 || !wsel[w][1]))
          mem[w] <= wrdata[0];
        else if (wsel[w][1])
          mem[w] <= wrdata[1];
      end
    end
  end

  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    dwdr_rd_port #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .RAM_DEPTH       (RAM_DEPTH),
      .DATA_WIDTH      (DATA_WIDTH),
      .NUM_WR          (NUM_WR),
      .WRITE_COLLISION (WRITE_COLLISION),
      .READ_COLLISION  (READ_COLLISION)
    ) u_rd (
      .clk         (aclk),
      .rst_n       (aresetn),
      .rden        (rden[r]),
      .rdaddr      (rdaddr[r]),
      .mem         (mem),
      .wren        (wren),
      .wraddr      (wraddr),
      .wrdata      (wrdata),
      .rddata      (rddata[r]),
      .rdcollision (rdcollision[r])
    );
  end
endmodule

// File: tb/tb_dual_write_dual_read_ram.sv
// ---------------------------------------------------------------------------
// tb_dual_write_dual_read_ram
//   Directed scenarios from the test plan, then randomized traffic. Every
//   result is checked against a word-array reference model.
// ---------------------------------------------------------------------------
module tb_dual_write_dual_read_ram;
  localparam int AW = 3;
  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  dual_write_dual_read_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  dual_write_dual_read_ram #(
    .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .DATA_WIDTH(DW),
    .WRITE_COLLISION(1), .READ_COLLISION(1)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_d [2];
  logic [1:0]    exp_c [2];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we1, input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                       input logic we2, input logic [AW-1:0] wa2, input logic [DW-1:0] wd2,
                       input logic re1, input logic [AW-1:0] ra1,
                       input logic re2, input logic [AW-1:0] ra2);
    bus.wren1 = we1; bus.wraddr1 = wa1; bus.wrdata1 = wd1;
    bus.wren2 = we2; bus.wraddr2 = wa2; bus.wrdata2 = wd2;
    bus.rden1 = re1; bus.rdaddr1 = ra1;
    bus.rden2 = re2; bus.rdaddr2 = ra2;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    for (int r = 0; r < 2; r++) begin exp_d[r] = '0; exp_c[r] = '0; end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rddata1"}, bus.rddata1, exp_d[0]);
    chk({tag, ".rddata2"}, bus.rddata2, exp_d[1]);
    chk({tag, ".rdcol1"}, {6'd0, bus.rdcollision1}, {6'd0, exp_c[0]});
    chk({tag, ".rdcol2"}, {6'd0, bus.rdcollision2}, {6'd0, exp_c[1]});
  endtask

  // One clock. The model is evaluated on the inputs present at the edge, and
  // the DUT is checked on the following falling edge.
  task automatic cycle(input string tag);
    logic          re [2];
    logic [AW-1:0] ra [2];
    logic [1:0]    c;
    @(posedge aclk);
    re[0] = bus.rden1; ra[0] = bus.rdaddr1;
    re[1] = bus.rden2; ra[1] = bus.rdaddr2;
    for (int r = 0; r < 2; r++) begin
      if (re[r]) begin
        c[0] = bus.wren1 && (bus.wraddr1 == ra[r]);
        c[1] = bus.wren2 && (bus.wraddr2 == ra[r]);
        exp_c[r] = c;
        if (c[0])      exp_d[r] = bus.wrdata1;
        else if (c[1]) exp_d[r] = bus.wrdata2;
        else           exp_d[r] = ref_mem[ra[r]];
      end else begin
        exp_c[r] = 2'b00;
      end
    end
    // Port 2 is applied first, so on the same address port 1 ends up in the word.
    if (bus.wren2) ref_mem[bus.wraddr2] = bus.wrdata2;
    if (bus.wren1) ref_mem[bus.wraddr1] = bus.wrdata1;
    @(negedge aclk);
    check_outputs(tag);
  endtask

  initial begin
    drive(0,0,0, 0,0,0, 0,0, 0,0);
    clear_model();
    aresetn = 1'b0;
    #10;
    check_outputs("reset");
    @(negedge aclk);
    aresetn = 1'b1;

    // Every word reads 0 after reset.
    for (int a = 0; a < DEPTH; a++) begin
      drive(0,0,0, 0,0,0, 1,AW'(a), 1,AW'(a));
      cycle("rst_read");
      chk("rst_read.v1", bus.rddata1, 8'h00);
    end

    // Concurrent writes to different addresses
    drive(1,3'd2,8'hA5, 1,3'd5,8'h3C, 0,0, 0,0);
    cycle("dist_wr");
    drive(0,0,0, 0,0,0, 1,3'd2, 1,3'd5);
    cycle("dist_rd");
    chk("dist_rd.a5", bus.rddata1, 8'hA5);
    chk("dist_rd.3c", bus.rddata2, 8'h3C);

    // Write collision: port 1 wins.
    drive(1,3'd4,8'h11, 1,3'd4,8'h22, 0,0, 0,0);
    cycle("wcol_wr");
    drive(0,0,0, 0,0,0, 1,3'd4, 1,3'd4);
    cycle("wcol_rd");
    chk("wcol_rd.11", bus.rddata2, 8'h11);

    // Read-during-write bypass on write port 1, then on write port 2.
    drive(1,3'd1,8'h77, 0,0,0, 1,3'd1, 1,3'd1);
    cycle("rcol_p1");
    chk("rcol_p1.flag", {6'd0, bus.rdcollision2}, 8'h01);
    drive(0,0,0, 1,3'd3,8'h66, 1,3'd3, 1,3'd3);
    cycle("rcol_p2");
    chk("rcol_p2.flag", {6'd0, bus.rdcollision1}, 8'h02);

    // Triple hit: read port 2 sees the winning data and both flags.
    drive(1,3'd6,8'h99, 1,3'd6,8'h55, 1,3'd2, 1,3'd6);
    cycle("triple");
    chk("triple.d2", bus.rddata2, 8'h99);
    chk("triple.c2", {6'd0, bus.rdcollision2}, 8'h03);

    // Hold: set a flag on read port 1, then drop rden1.
    drive(0,0,0, 1,3'd2,8'hA5, 1,3'd2, 0,0);
    cycle("hold_set");
    drive(0,0,0, 0,0,0, 0,3'd7, 0,0);
    cycle("hold");
    chk("hold.a5", bus.rddata1, 8'hA5);

    // Random traffic. A narrow address range sometimes forces collisions.
    for (int i = 0; i < 400; i++) begin
      int amax;
      amax = ($urandom_range(0, 1) == 0) ? 1 : 7;
      drive($urandom_range(0,1), AW'($urandom_range(0,amax)), DW'($urandom),
            $urandom_range(0,1), AW'($urandom_range(0,amax)), DW'($urandom),
            $urandom_range(0,1), AW'($urandom_range(0,amax)),
            $urandom_range(0,1), AW'($urandom_range(0,amax)));
      cycle("rand");
    end

    // Fill, then reset between edges mid-operation.
    for (int a = 0; a < DEPTH; a++) begin
      drive(1,AW'(a),DW'(8'hF0 + a), 0,0,0, 1,AW'(a), 1,AW'(a));
      cycle("fill");
    end
    drive(0,0,0, 0,0,0, 1,3'd3, 1,3'd5);
    #2 aresetn = 1'b0;
    #1;
    clear_model();
    check_outputs("midrst");
    #1 aresetn = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      drive(0,0,0, 0,0,0, 1,AW'(a), 1,AW'(DEPTH-1-a));
      cycle("post_rst");
      chk("post_rst.v2", bus.rddata2, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dual_write_dual_read_ram.md
Name: dual_write_dual_read_ram

Overview:
- Register-based multi-port RAM with two independent write ports and two independent read ports, all on one clock.
- Optional write-collision arbitration, selected by parameter, for two writes to the same address in one cycle.
- Optional read-during-write bypass with collision flags, selected by parameter, so each read port can report when it hits an address being written that cycle.
- Used as a small shared storage block between agents (agent 1 = port pair 1, agent 2 = port pair 2).

Parameters:
- ADDR_WIDTH, 3, address bus width of every port.
- RAM_DEPTH, 2**ADDR_WIDTH (8), number of words; addresses at or above RAM_DEPTH are ignored on writes and read as 0.
- DATA_WIDTH, 8, word width.
- WRITE_COLLISION, 1, 1 = deterministic arbitration of same-address dual writes; 0 = none.
- READ_COLLISION, 1, 1 = read-during-write bypass and collision flags enabled; 0 = disabled.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- wren1  in  1  write enable, port 1.
- wraddr1  in  ADDR_WIDTH  write address, port 1.
- wrdata1  in  DATA_WIDTH  write data, port 1.
- wren2  in  1  write enable, port 2.
- wraddr2  in  ADDR_WIDTH  write address, port 2.
- wrdata2  in  DATA_WIDTH  write data, port 2.
- rden1  in  1  read enable, port 1.
- rdaddr1  in  ADDR_WIDTH  read address, port 1.
- rddata1  out  DATA_WIDTH  registered read data, port 1.
- rdcollision1  out  2  collision flags, port 1: bit0 = hit write port 1, bit1 = hit write port 2.
- rden2  in  1  read enable, port 2.
- rdaddr2  in  ADDR_WIDTH  read address, port 2.
- rddata2  out  DATA_WIDTH  registered read data, port 2.
- rdcollision2  out  2  collision flags, port 2, same encoding as port 1.

Behaviour:
- Reset: aresetn low asynchronously clears all RAM words, rddata1/2 and rdcollision1/2 to 0. Ports are usable from the first rising edge after release.
- Write:
  - On a rising edge with wrenN=1, mem[wraddrN] takes wrdataN.
  - Writes to different addresses both land in the same cycle.
- Write collision (wren1 = wren2 = 1, wraddr1 == wraddr2):
  - WRITE_COLLISION=1: port 1 wins; mem takes wrdata1 and the port-2 write is dropped.
  - WRITE_COLLISION=0: the word's content is undefined until it is next written; verification must not check it.
- Read:
  - Latency is 1 cycle. With rdenN=1 at edge k, rddataN after edge k holds mem[rdaddrN].
  - With rdenN=0, rddataN holds its previous value and rdcollisionN is cleared to 0 on the edge.
  - Both read ports may read any addresses, including the same one, in the same cycle without interference.
- Read during write (rdenN=1, rdaddrN equal to an active write address in the same cycle):
  - READ_COLLISION=1:
    - rdcollisionN[0] = wren1 & (wraddr1==rdaddrN); rdcollisionN[1] = wren2 & (wraddr2==rdaddrN). Both bits are registered alongside rddataN.
    - rddataN returns the new write data (bypass). On a dual-write collision, it returns the winning data (wrdata1 when WRITE_COLLISION=1).
  - READ_COLLISION=0: rdcollisionN stays 0 and rddataN returns the old content (read-before-write).
- No-collision read: rdcollisionN = 2'b00.
- Address width: RAM_DEPTH ≤ 2**ADDR_WIDTH; no wrap-around is applied.

Test Plan:
- Reset then read: assert aresetn low for 10 ns, release, read addresses 0..7 on both ports -> rddata1 = rddata2 = 0 and rdcollision = 0 for every address.
- Concurrent distinct writes: port 1 writes 8'hA5 to addr 2 while port 2 writes 8'h3C to addr 5; next cycle port 1 reads 2 and port 2 reads 5 -> 8'hA5 and 8'h3C one cycle later, collisions 2'b00.
- Write collision: both ports write addr 4 (8'h11 on port 1, 8'h22 on port 2); later read addr 4 -> 8'h11.
- Read collision:
  - Port 1 writes 8'h77 to addr 1 while both read ports read addr 1 -> rddata1 = rddata2 = 8'h77 and rdcollision1 = rdcollision2 = 2'b01.
  - Repeat using write port 2 -> both flags 2'b10.
- Triple hit: both write ports target addr 6 (8'h99 on port 1, 8'h55 on port 2) while read port 2 reads addr 6 -> rddata2 = 8'h99, rdcollision2 = 2'b11.
- Hold and reset mid-operation:
  - Drop rden1 after reading 8'hA5 -> rddata1 stays 8'hA5, rdcollision1 = 0.
  - Assert aresetn low between edges -> outputs go to 0 immediately and all words read 0 afterwards.
